// File: rtl/salu_operand_fetch_if.sv
// Signal bundle between the SALU operand-fetch unit and its neighbours (decode, SGPR read port, execute).
// master is the fetch unit's view; slave is the surrounding pipeline's view. SALU_OPFETCH_BYPASS_EN adds writeback forwarding.
interface salu_operand_fetch_if #(
    parameter int COMMON_W = 32
);
    logic                op_valid;
    logic [7:0]          op_src0;
    logic [7:0]          op_src1;
    logic [6:0]          op_dest;
    logic [COMMON_W-1:0] op_common;

    logic                rd_req_valid;
    logic [6:0]          rd_req_addr;
    logic                rd_resp_valid;
    logic [31:0]         rd_resp_data;

    logic                exec_valid;
    logic                exec_ready;
    logic [31:0]         exec_src0;
    logic [31:0]         exec_src1;
    logic [6:0]          exec_dest;
    logic [COMMON_W-1:0] exec_common;

    logic                overflow;
    logic                illegal_src;

`ifdef SALU_OPFETCH_BYPASS_EN
    logic                wb_valid;
    logic [6:0]          wb_addr;
    logic [31:0]         wb_data;

    modport master (
        input  op_valid, op_src0, op_src1, op_dest, op_common,
        output rd_req_valid, rd_req_addr,
        input  rd_resp_valid, rd_resp_data,
        output exec_valid, exec_src0, exec_src1, exec_dest, exec_common,
        input  exec_ready,
        output overflow, illegal_src,
        input  wb_valid, wb_addr, wb_data
    );

    modport slave (
        output op_valid, op_src0, op_src1, op_dest, op_common,
        input  rd_req_valid, rd_req_addr,
        output rd_resp_valid, rd_resp_data,
        input  exec_valid, exec_src0, exec_src1, exec_dest, exec_common,
        output exec_ready,
        input  overflow, illegal_src,
        output wb_valid, wb_addr, wb_data
    );
`else
    modport master (
        input  op_valid, op_src0, op_src1, op_dest, op_common,
        output rd_req_valid, rd_req_addr,
        input  rd_resp_valid, rd_resp_data,
        output exec_valid, exec_src0, exec_src1, exec_dest, exec_common,
        input  exec_ready,
        output overflow, illegal_src
    );

    modport slave (
        output op_valid, op_src0, op_src1, op_dest, op_common,
        input  rd_req_valid, rd_req_addr,
        output rd_resp_valid, rd_resp_data,
        input  exec_valid, exec_src0, exec_src1, exec_dest, exec_common,
        output exec_ready,
        input  overflow, illegal_src
    );
`endif
endinterface

// File: rtl/salu_operand_fetch.sv
// SALU operand fetch: buffers decoded SOP2 ops and resolves both sources from the SGPR read port or inline constants.
// Optional macro SALU_OPFETCH_BYPASS_EN forwards matching SALU writeback data in place of an SGPR read.
//
// state | meaning
// IDLE  | no working op; pops the FIFO when it holds an entry
// SRC0  | resolve operand 0: issue SGPR read or latch constant
// WAIT0 | waiting for the SGPR read response for operand 0
// SRC1  | resolve operand 1: issue SGPR read or latch constant
// WAIT1 | waiting for the SGPR read response for operand 1
// OUT   | resolved op presented to execute until accepted
module salu_operand_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int COMMON_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    salu_operand_fetch_if.master bus
);
    localparam int             PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRC0,
        S_WAIT0,
        S_SRC1,
        S_WAIT1,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [7:0]          src0;
        logic [7:0]          src1;
        logic [6:0]          dest;
        logic [COMMON_W-1:0] common;
    } op_t;

    typedef struct packed {
        logic        is_reg;
        logic        illegal;
        logic [31:0] value;
    } src_dec_t;

    op_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             drop;

    state_t      state;
    state_t      state_nxt;
    op_t         work_op;
    logic [31:0] src0_val;
    logic [31:0] src1_val;
    logic        overflow_q;

    logic        is_op1;
    logic [7:0]  cur_enc;
    src_dec_t    cur_dec;
    logic        wb_hit;
    logic [31:0] wb_data;
    logic        ld_en;
    logic [31:0] ld_val;
    logic        rd_req;
    logic        illegal;

    // 0..127 SGPR, 128..192 small positive, 193..208 small negative, rest unsupported.
    function automatic src_dec_t decode_src(input logic [7:0] enc);
        src_dec_t d;
        d = '0;
        if (!enc[7]) begin
            d.is_reg = 1'b1;
        end else if (enc <= 8'd192) begin
            d.value = {24'd0, 8'(enc - 8'd128)};
        end else if (enc <= 8'd208) begin
            d.value = 32'd0 - (32'(enc) - 32'd192);
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign push       = bus.op_valid && (!fifo_full || pop);
    assign drop       = bus.op_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.op_src0, bus.op_src1, bus.op_dest, bus.op_common};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign is_op1  = (state == S_SRC1) || (state == S_WAIT1);
    assign cur_enc = is_op1 ? work_op.src1 : work_op.src0;
    assign cur_dec = decode_src(cur_enc);

`ifdef SALU_OPFETCH_BYPASS_EN
    assign wb_hit  = bus.wb_valid && (bus.wb_addr == cur_enc[6:0]);
    assign wb_data = bus.wb_data;
`else
    assign wb_hit  = 1'b0;
    assign wb_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        illegal   = 1'b0;
        ld_en     = 1'b0;
        ld_val    = cur_dec.value;
        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = S_SRC0;
                end
            end
            S_SRC0, S_SRC1: begin
                illegal = cur_dec.illegal;
                if (cur_dec.is_reg && !wb_hit) begin
                    rd_req    = 1'b1;
                    state_nxt = is_op1 ? S_WAIT1 : S_WAIT0;
                end else begin
                    ld_en     = 1'b1;
                    state_nxt = is_op1 ? S_OUT : S_SRC1;
                    if (cur_dec.is_reg) begin
                        ld_val = wb_data;
                    end
                end
            end
            S_WAIT0, S_WAIT1: begin
                if (bus.rd_resp_valid) begin
                    ld_en     = 1'b1;
                    ld_val    = wb_hit ? wb_data : bus.rd_resp_data;
                    state_nxt = is_op1 ? S_OUT : S_SRC1;
                end
            end
            S_OUT: begin
                if (bus.exec_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_op  <= '0;
            src0_val <= '0;
            src1_val <= '0;
        end else begin
            if (pop) begin
                work_op <= fifo_mem[rd_ptr];
            end
            if (ld_en) begin
                if (is_op1) begin
                    src1_val <= ld_val;
                end else begin
                    src0_val <= ld_val;
                end
            end
        end
    end

    assign bus.rd_req_valid = rd_req;
    assign bus.rd_req_addr  = rd_req ? cur_enc[6:0] : 7'd0;
    assign bus.exec_valid   = (state == S_OUT);
    assign bus.exec_src0    = src0_val;
    assign bus.exec_src1    = src1_val;
    assign bus.exec_dest    = work_op.dest;
    assign bus.exec_common  = work_op.common;
    assign bus.overflow     = overflow_q;
    assign bus.illegal_src  = illegal;
endmodule

// File: tb/tb_salu_operand_fetch.sv
// Scoreboard bench for salu_operand_fetch: directed ops push expected results, a monitor checks each accepted exec beat.
module tb_salu_operand_fetch;
    typedef struct {
        logic [31:0] s0;
        logic [31:0] s1;
        logic [6:0]  d;
        logic [31:0] c;
    } exp_t;

    logic clk;
    logic rst;
    salu_operand_fetch_if #(.COMMON_W(32)) bus ();

    salu_operand_fetch #(.FIFO_DEPTH(4), .COMMON_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic [6:0]  req_log[$];
    logic [31:0] sgpr_mem [128];
    logic        resp_en   = 1'b1;
    int          stray_cnt = 0;
    int          stray_done = 0;
    int          illegal_cnt = 0;
    int          exec_seen = 0;
    logic [6:0]  req_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted exec beat against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.illegal_src === 1'b1) illegal_cnt++;
            if (bus.exec_valid === 1'b1) exec_seen++;
            if (bus.exec_valid === 1'b1 && bus.exec_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_exec", {57'd0, bus.exec_dest}, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("exec_src0", bus.exec_src0, e.s0);
                    check("exec_src1", bus.exec_src1, e.s1);
                    check("exec_dest", bus.exec_dest, e.d);
                    check("exec_common", bus.exec_common, e.c);
                end
            end
        end
    end

    // SGPR responder: one-cycle read latency, plus injected stray responses on demand.
    initial begin
        bus.rd_resp_valid = 1'b0;
        bus.rd_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (resp_en && bus.rd_req_valid === 1'b1) begin
                req_addr = bus.rd_req_addr;
                req_log.push_back(req_addr);
                @(posedge clk); #1;
                bus.rd_resp_valid = 1'b1;
                bus.rd_resp_data  = sgpr_mem[req_addr];
                @(posedge clk); #1;
                bus.rd_resp_valid = 1'b0;
                bus.rd_resp_data  = '0;
            end else if (stray_cnt != stray_done) begin
                @(posedge clk); #1;
                bus.rd_resp_valid = 1'b1;
                bus.rd_resp_data  = 32'h0000_0077;
                @(posedge clk); #1;
                bus.rd_resp_valid = 1'b0;
                bus.rd_resp_data  = '0;
                stray_done++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_op(input logic [31:0] s0, input logic [31:0] s1, input logic [6:0] d, input logic [31:0] c);
        exp_t e;
        e.s0 = s0; e.s1 = s1; e.d = d; e.c = c;
        sb.push_back(e);
    endtask

    task automatic drive_op(input logic [7:0] s0, input logic [7:0] s1, input logic [6:0] d, input logic [31:0] c);
        bus.op_valid  = 1'b1;
        bus.op_src0   = s0;
        bus.op_src1   = s1;
        bus.op_dest   = d;
        bus.op_common = c;
        @(posedge clk); #1;
        bus.op_valid  = 1'b0;
    endtask

    // Issues one op into an idle unit and returns cycles from op_valid to exec_valid.
    task automatic run_op(input logic [7:0] s0, input logic [7:0] s1, input logic [6:0] d, input logic [31:0] c, output int lat);
        drive_op(s0, s1, d, c);
        lat = 1;
        while (lat < 60) begin
            @(negedge clk);
            if (bus.exec_valid === 1'b1) break;
            lat++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int lat;
    int ill0;
    int seen0;
    int guard;

    initial begin
        for (int i = 0; i < 128; i++) sgpr_mem[i] = 32'h0;
        sgpr_mem[0]   = 32'h1111_0000;
        sgpr_mem[5]   = 32'h0000_1234;
        sgpr_mem[10]  = 32'h0000_ABCD;
        sgpr_mem[127] = 32'h5A5A_0001;
        rst = 1'b1;
        bus.op_valid = 1'b0; bus.op_src0 = '0; bus.op_src1 = '0; bus.op_dest = '0; bus.op_common = '0;
        bus.exec_ready = 1'b1;
`ifdef SALU_OPFETCH_BYPASS_EN
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_exec_valid", bus.exec_valid, 0);
        check("rst_rd_req", bus.rd_req_valid, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_exec_src0", bus.exec_src0, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        expect_op(32'h2, 32'hFFFF_FFF8, 7'd3, 32'hC0FF_EE01);
        run_op(8'd130, 8'd200, 7'd3, 32'hC0FF_EE01, lat);
        check("inline_latency", lat, 4);
        check("inline_no_req", req_log.size(), 0);

        req_log.delete();
        expect_op(32'h1234, 32'hABCD, 7'd9, 32'h0000_0042);
        run_op(8'd5, 8'd10, 7'd9, 32'h0000_0042, lat);
        check("reg_latency", lat, 6);
        check("reg_req_count", req_log.size(), 2);
        if (req_log.size() == 2) begin
            check("reg_req_addr0", req_log[0], 5);
            check("reg_req_addr1", req_log[1], 10);
        end

        ill0 = illegal_cnt;
        expect_op(32'h0, 32'h0, 7'd4, 32'h1);
        run_op(8'd255, 8'd128, 7'd4, 32'h1, lat);
        check("illegal_latency", lat, 4);
        check("illegal_pulse", illegal_cnt - ill0, 1);

        expect_op(32'h40, 32'hFFFF_FFF0, 7'd5, 32'h2);
        run_op(8'd192, 8'd208, 7'd5, 32'h2, lat);
        check("bound_latency", lat, 4);

        req_log.delete();
        expect_op(32'hFFFF_FFFF, 32'h5A5A_0001, 7'd6, 32'h3);
        run_op(8'd193, 8'd127, 7'd6, 32'h3, lat);
        check("mixed_latency", lat, 5);
        check("mixed_req_count", req_log.size(), 1);

        ill0 = illegal_cnt;
        expect_op(32'h1111_0000, 32'h0, 7'd7, 32'h4);
        run_op(8'd0, 8'd209, 7'd7, 32'h4, lat);
        check("reg_illegal_latency", lat, 5);
        check("reg_illegal_pulse", illegal_cnt - ill0, 1);
        check("no_overflow_yet", bus.overflow, 0);

        // Backpressure: dest 1 parks in OUT, 2..5 fill the FIFO, 6 is dropped.
        bus.exec_ready = 1'b0;
        for (int d = 1; d <= 6; d++) begin
            if (d <= 5) expect_op(32'(d), 32'hFFFF_FFFF, 7'(d), 32'(16 + d));
            drive_op(8'(128 + d), 8'd193, 7'(d), 32'(16 + d));
        end
        repeat (3) @(negedge clk);
        check("bp_exec_valid", bus.exec_valid, 1);
        check("bp_exec_dest", bus.exec_dest, 1);
        check("bp_overflow", bus.overflow, 1);
        @(posedge clk); #1;
        bus.exec_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk); guard++;
        end
        check("bp_drain", sb.size(), 0);
        repeat (8) @(negedge clk);
        check("bp_dropped_not_seen", bus.exec_valid, 0);
        check("bp_overflow_sticky", bus.overflow, 1);
        @(posedge clk); #1;

        // Reset while waiting on an SGPR read; a late response must be ignored.
        resp_en = 1'b0;
        drive_op(8'd5, 8'd10, 7'd11, 32'h5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_exec_valid", bus.exec_valid, 0);
        check("midrst_overflow", bus.overflow, 0);
        check("midrst_exec_dest", bus.exec_dest, 0);
        check("midrst_rd_req", bus.rd_req_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        seen0 = exec_seen;
        stray_cnt++;
        repeat (12) @(negedge clk);
        check("midrst_no_exec", exec_seen - seen0, 0);
        check("midrst_stray_sent", stray_done, stray_cnt);
        resp_en = 1'b1;
        @(posedge clk); #1;

        expect_op(32'h1, 32'h1, 7'd8, 32'h6);
        run_op(8'd129, 8'd129, 7'd8, 32'h6, lat);
        check("post_rst_latency", lat, 4);

`ifdef SALU_OPFETCH_BYPASS_EN
        req_log.delete();
        bus.wb_valid = 1'b1; bus.wb_addr = 7'd7; bus.wb_data = 32'hDEAD_BEEF;
        expect_op(32'hDEAD_BEEF, 32'hABCD, 7'd10, 32'h7);
        run_op(8'd7, 8'd10, 7'd10, 32'h7, lat);
        bus.wb_valid = 1'b0;
        check("bypass_latency", lat, 5);
        check("bypass_req_count", req_log.size(), 1);
        if (req_log.size() == 1) check("bypass_req_addr", req_log[0], 10);
`endif

        repeat (4) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/salu_operand_fetch.md
Name: salu_operand_fetch

Overview:
- Consumer of the registered SALU operation stream produced by the SOP2 decode stage. That stream is valid-only, with no backpressure.
- Buffers operations in a small FIFO and resolves both source operands. Operands come from the SGPR file through a single request/response read port, or from the SOP2 inline-constant encoding.
- Presents a fully resolved operation to the SALU execute stage over a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, operation buffer entries (power of two, >=2).
- COMMON_W, 32, width of the opaque common-parameter (lookup) field carried through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  decoded operation valid (single-cycle beat, no ready)
- op_src0  in  8  SOP2 source 0 encoding
- op_src1  in  8  SOP2 source 1 encoding
- op_dest  in  7  destination SGPR
- op_common  in  COMMON_W  common parameters, passed through
- rd_req_valid  out  1  SGPR read request (single-cycle pulse)
- rd_req_addr  out  7  SGPR read address
- rd_resp_valid  in  1  read data valid
- rd_resp_data  in  32  read data
- exec_valid  out  1  resolved operation valid
- exec_ready  in  1  execute stage accepts
- exec_src0  out  32  resolved operand 0
- exec_src1  out  32  resolved operand 1
- exec_dest  out  7  destination SGPR
- exec_common  out  COMMON_W  common parameters
- overflow  out  1  sticky: an operation was dropped
- illegal_src  out  1  one-cycle pulse: unsupported source encoding

Behaviour:
- Reset (async, rst=1): FIFO empty, FSM IDLE, all outputs 0, overflow=0. A reset mid-operation abandons the working op. Any rd_resp arriving after reset release with no outstanding request is ignored.
- FIFO push: on every op_valid beat.
  - When full, the push is accepted only if a pop occurs in the same cycle.
  - Otherwise the beat is dropped and overflow=1 until reset.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO pop: only in IDLE with FIFO non-empty. The popped entry loads the working registers.
- Source decode, per operand:
  - 0..127: SGPR read, address = enc[6:0].
  - 128..192: inline constant, value = enc-128 (0..64), zero-extended to 32 bits.
  - 193..208: inline constant, value = -(enc-192) (-1..-16), sign-extended to 32 bits.
  - 209..255: illegal; value 0, illegal_src pulses for one cycle in the SRCn state.
- FSM:
  - IDLE: if FIFO non-empty, pop and go to SRC0.
  - SRC0: if the operand is a register, pulse rd_req_valid with rd_req_addr and go to WAIT0. Otherwise latch the constant and go to SRC1.
  - WAIT0: on rd_resp_valid, latch rd_resp_data and go to SRC1. Hold indefinitely otherwise.
  - SRC1 / WAIT1: same as SRC0 / WAIT0 for operand 1, then go to OUT.
  - OUT: exec_valid=1 with all exec_* fields stable. On exec_valid && exec_ready, go to IDLE (exec_valid drops the next cycle).
- At most one read is outstanding. Responses return in order at any latency >=1. rd_resp_valid outside WAIT0/WAIT1 is ignored.
- Latency: op_valid at cycle 0, FIFO empty, FSM idle, ready high:
  - Both operands inline: exec_valid at cycle 4.
  - Both operands registers, 1-cycle read response: exec_valid at cycle 6.
- Throughput: one operation per FSM traversal. No overlap between operations.
- Same-cycle push and pop on an empty FIFO: the pushed op is not popped that cycle. It becomes visible the next cycle.

Optional Feature:
- Macro: SALU_OPFETCH_BYPASS_EN.
- Defined: adds ports wb_valid (in 1), wb_addr (in 7), wb_data (in 32) from SALU writeback.
  - In SRCn, if the operand is a register and wb_valid && wb_addr==enc[6:0], wb_data is latched directly. No rd_req is issued, and the FSM skips WAITn.
  - In WAITn, a matching wb in the same cycle as rd_resp_valid takes priority over rd_resp_data.
- Undefined: the ports are absent and all register operands go through the read port.

Test Plan:
- Inline sources: src0=130, src1=200, dest=3 -> no rd_req. exec_valid at cycle 4 with src0=0x00000002, src1=0xFFFFFFF8, dest=3.
- Register sources: src0=5, src1=10, responder returns 0x00001234 then 0x0000ABCD after 1 cycle -> rd_req addr 5 then 10. exec_valid at cycle 6 with src0=0x1234, src1=0xABCD.
- Backpressure/overflow: FIFO_DEPTH=4, exec_ready=0, six back-to-back inline ops with dest 1..6 -> dest 1 held in OUT, 2..5 buffered, 6 dropped, overflow=1. Raising exec_ready yields dests 1,2,3,4,5 in order; overflow stays 1.
- Illegal source: src0=255, src1=128 -> illegal_src one-cycle pulse. exec_src0=0, exec_src1=0.
- Reset mid-read: assert rst while in WAIT0, deliver rd_resp after release -> exec_valid never asserts, all outputs 0, FIFO empty.
- Bypass (macro defined): src0=7, wb_valid=1, wb_addr=7, wb_data=0xDEADBEEF during SRC0 -> no rd_req for src0, exec_src0=0xDEADBEEF.
